// File: rtl/ultrasonic_scan_controller.sv
// rtl/ultrasonic_scan_controller.sv - round-robin ultrasonic sensor trigger/echo sequencer
// One shot per sensor visit: trigger, wait for echo, time its width, report, then guard gap.
module ultrasonic_scan_controller #(
  parameter int NUM_SENSORS    = 4,
  parameter int IDX_W          = 2,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1200000,
  parameter int GUARD_CYCLES   = 100000,
  parameter int CNT_W          = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo_rise,
  input  logic [NUM_SENSORS-1:0] echo_fall,
  output logic [NUM_SENSORS-1:0] trig,
  output logic                   busy,
  output logic                   meas_valid,
  output logic [IDX_W-1:0]       meas_idx,
  output logic [CNT_W-1:0]       meas_count,
  output logic                   meas_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_REPORT,
    S_GUARD
  } state_e;

  localparam logic [CNT_W-1:0] TRIG_LIM    = CNT_W'(TRIG_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_LIM   = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_SENSORS - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_SENSORS-1:0] trig_q, trig_d;
  logic                   busy_q, busy_d;
  logic                   meas_valid_q, meas_valid_d;
  logic [IDX_W-1:0]       meas_idx_q, meas_idx_d;
  logic [CNT_W-1:0]       meas_count_q, meas_count_d;
  logic                   meas_timeout_q, meas_timeout_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             rise_sel;
  logic             fall_sel;

  // cnt_inc is the number of cycles spent in the current state including this one.
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign rise_sel = echo_rise[idx_q];
  assign fall_sel = echo_fall[idx_q];

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_inc;
    meas_valid_d   = 1'b0;
    meas_idx_d     = meas_idx_q;
    meas_count_d   = meas_count_q;
    meas_timeout_d = meas_timeout_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (cnt_inc == TRIG_LIM) begin
          state_d = S_WAIT_RISE;
          cnt_d   = '0;
        end
      end
      S_WAIT_RISE: begin
        // A fall arriving together with the rise is deliberately dropped.
        if (rise_sel) begin
          state_d = S_MEASURE;
          cnt_d   = '0;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          state_d        = S_REPORT;
          cnt_d          = '0;
          meas_valid_d   = 1'b1;
          meas_idx_d     = idx_q;
          meas_count_d   = '0;
          meas_timeout_d = 1'b1;
        end
      end
      S_MEASURE: begin
        if (fall_sel) begin
          state_d        = S_REPORT;
          cnt_d          = '0;
          meas_valid_d   = 1'b1;
          meas_idx_d     = idx_q;
          meas_count_d   = cnt_inc;
          meas_timeout_d = 1'b0;
        end else if (cnt_inc == TIMEOUT_LIM) begin
          state_d        = S_REPORT;
          cnt_d          = '0;
          meas_valid_d   = 1'b1;
          meas_idx_d     = idx_q;
          meas_count_d   = TIMEOUT_LIM;
          meas_timeout_d = 1'b1;
        end
      end
      S_REPORT: begin
        state_d = S_GUARD;
        cnt_d   = '0;
        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
      S_GUARD: begin
        if (cnt_inc == GUARD_LIM) begin
          state_d = enable ? S_TRIG : S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    trig_d = '0;
    if (state_d == S_TRIG) begin
      trig_d[idx_d] = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      trig_q         <= '0;
      busy_q         <= 1'b0;
      meas_valid_q   <= 1'b0;
      meas_idx_q     <= '0;
      meas_count_q   <= '0;
      meas_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      trig_q         <= trig_d;
      busy_q         <= busy_d;
      meas_valid_q   <= meas_valid_d;
      meas_idx_q     <= meas_idx_d;
      meas_count_q   <= meas_count_d;
      meas_timeout_q <= meas_timeout_d;
    end
  end

  assign trig         = trig_q;
  assign busy         = busy_q;
  assign meas_valid   = meas_valid_q;
  assign meas_idx     = meas_idx_q;
  assign meas_count   = meas_count_q;
  assign meas_timeout = meas_timeout_q;

endmodule
